// File: rtl/id_operand_stage.sv
// ID back-end: operand forwarding, load-use hazard stall and registered ID/EX slot.
// Define ID_STALL_CNT_EN to enable the saturating load-use stall counter.
module id_operand_stage #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int CW      = 16,
  parameter int NUM_FWD = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         in_pc,
  input  logic [CW-1:0]         in_ctrl,
  input  logic                  in_rs_read,
  input  logic                  in_rt_read,
  input  logic [4:0]            in_rs_addr,
  input  logic [4:0]            in_rt_addr,
  input  logic [DW-1:0]         in_imm,
  input  logic                  in_we,
  input  logic [4:0]            in_w_addr,
  input  logic                  in_is_load,
  output logic [4:0]            rs_addr,
  output logic [4:0]            rt_addr,
  input  logic [DW-1:0]         rs_data,
  input  logic [DW-1:0]         rt_data,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [5*NUM_FWD-1:0]  fwd_addr,
  input  logic [DW*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]    fwd_pending,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW-1:0]         out_pc,
  output logic [CW-1:0]         out_ctrl,
  output logic [4:0]            out_w_addr,
  output logic                  out_we,
  output logic                  out_is_load,
  output logic [DW-1:0]         out_reg1,
  output logic [DW-1:0]         out_reg2,
  output logic [1:0]            stage_state,
  output logic [31:0]           stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LU = 2'd1,
    STALL_BP = 2'd2
  } state_t;

  state_t state_q;

  // Returns {hazard, operand}; the youngest matching channel wins.
  function automatic logic [DW:0] resolve(
    input logic          rd,
    input logic [4:0]    a,
    input logic [DW-1:0] rf
  );
    logic [DW:0] r;
    logic        hit;
    r   = {1'b0, rf};
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_we[i] && fwd_addr[5*i +: 5] == a) begin
        hit = 1'b1;
        r   = {fwd_pending[i], fwd_data[DW*i +: DW]};
      end
    end
    if (a == 5'd0) r = '0;
    if (!rd) r = {1'b0, in_imm};
    return r;
  endfunction

  logic [DW:0] res1;
  logic [DW:0] res2;
  logic        hazard;
  logic        accept;

  assign rs_addr = in_rs_addr;
  assign rt_addr = in_rt_addr;

  always_comb begin
    res1 = resolve(in_rs_read, in_rs_addr, rs_data);
    res2 = resolve(in_rt_read, in_rt_addr, rt_data);
  end

  assign hazard   = in_valid && (res1[DW] || res2[DW]);
  assign in_ready = !rst && !flush && !hazard
                    && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign stage_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_ctrl    <= '0;
      out_w_addr  <= '0;
      out_we      <= 1'b0;
      out_is_load <= 1'b0;
      out_reg1    <= '0;
      out_reg2    <= '0;
      state_q     <= RUN;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_ctrl    <= in_ctrl;
        out_w_addr  <= in_w_addr;
        out_we      <= in_we;
        out_is_load <= in_is_load;
        out_reg1    <= res1[DW-1:0];
        out_reg2    <= res2[DW-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (1'b1)
        flush:  state_q <= RUN;
        hazard: state_q <= STALL_LU;
        in_valid && out_valid && !out_ready:
          state_q <= STALL_BP;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state_q == STALL_LU && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: operand table with scoreboard,
// then load-use, backpressure, flush and stall-counter sequences.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [15:0] in_ctrl;
  logic        in_rs_read;
  logic        in_rt_read;
  logic [4:0]  in_rs_addr;
  logic [4:0]  in_rt_addr;
  logic [31:0] in_imm;
  logic        in_we;
  logic [4:0]  in_w_addr;
  logic        in_is_load;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [2:0]  fwd_pending;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [15:0] out_ctrl;
  logic [4:0]  out_w_addr;
  logic        out_we;
  logic        out_is_load;
  logic [31:0] out_reg1;
  logic [31:0] out_reg2;
  logic [1:0]  stage_state;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_rs_read(in_rs_read), .in_rt_read(in_rt_read),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_imm(in_imm), .in_we(in_we), .in_w_addr(in_w_addr),
    .in_is_load(in_is_load),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_w_addr(out_w_addr), .out_we(out_we),
    .out_is_load(out_is_load),
    .out_reg1(out_reg1), .out_reg2(out_reg2),
    .stage_state(stage_state), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rs_read;
    logic        rt_read;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [31:0] imm;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [2:0]  fwe;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [2:0]  fp;
    logic        exp_rdy;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [4:0]  wa;
    logic        ld;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  vec_t vt[10];
  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_pc = '0; in_ctrl = '0;
    in_rs_read = 0; in_rt_read = 0; in_rs_addr = '0;
    in_rt_addr = '0; in_imm = '0; in_we = 0; in_w_addr = '0;
    in_is_load = 0; rs_data = '0; rt_data = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0;
    fwd_pending = '0; out_ready = 1;
  endtask

  function automatic vec_t mk(
    input logic rsr, input logic rtr,
    input logic [4:0] rsa, input logic [4:0] rta,
    input logic [31:0] imm, input logic [31:0] rsd,
    input logic [31:0] rtd, input logic [2:0] fwe,
    input logic [14:0] fa, input logic [95:0] fd,
    input logic [2:0] fp, input logic rdy,
    input logic [31:0] r1, input logic [31:0] r2);
    vec_t v;
    v.rs_read = rsr; v.rt_read = rtr; v.rs_a = rsa; v.rt_a = rta;
    v.imm = imm; v.rs_d = rsd; v.rt_d = rtd; v.fwe = fwe;
    v.fa = fa; v.fd = fd; v.fp = fp; v.exp_rdy = rdy;
    v.exp_r1 = r1; v.exp_r2 = r2;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1;
    #1 chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    // Two channels write r5; youngest wins.
    vt[0] = mk(1, 0, 5, 0, 32'h77, 32'hBAD, 0, 3'b011,
               {5'd0, 5'd5, 5'd5}, {32'h0, 32'h22, 32'h11},
               3'b000, 1, 32'h11, 32'h77);
    vt[1] = mk(1, 1, 3, 0, 0, 32'hAAAA, 32'hBEEF, 3'b001,
               {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hDEAD},
               3'b000, 1, 32'hAAAA, 32'h0);
    vt[2] = mk(1, 1, 7, 9, 0, 32'h100, 32'h200, 3'b100,
               {5'd10, 5'd0, 5'd0}, {32'h310, 32'h0, 32'h0},
               3'b000, 1, 32'h100, 32'h200);
    vt[3] = mk(0, 1, 9, 9, 32'h42, 32'h100, 32'h200, 3'b100,
               {5'd9, 5'd9, 5'd0}, {32'h999, 32'h555, 32'h0},
               3'b000, 1, 32'h42, 32'h999);
    vt[4] = mk(1, 1, 4, 4, 0, 0, 0, 3'b011,
               {5'd0, 5'd4, 5'd4}, {32'h0, 32'h88, 32'h44},
               3'b010, 1, 32'h44, 32'h44);
    vt[5] = mk(1, 1, 2, 6, 0, 32'h20, 0, 3'b010,
               {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66, 32'h0},
               3'b010, 0, 0, 0);
    vt[6] = mk(0, 1, 6, 0, 32'h5, 0, 32'h7, 3'b001,
               {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h6},
               3'b001, 1, 32'h5, 32'h0);
    vt[7] = mk(1, 0, 3, 0, 32'h9, 32'h33, 0, 3'b000,
               {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h3},
               3'b001, 1, 32'h33, 32'h9);
    vt[8] = mk(1, 1, 0, 1, 0, 32'h1, 32'h11, 3'b001,
               {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hF0},
               3'b001, 1, 32'h0, 32'h11);
    vt[9] = mk(1, 0, 12, 0, 32'h1, 0, 0, 3'b101,
               {5'd12, 5'd0, 5'd12}, {32'hC2, 32'h0, 32'hC0},
               3'b001, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_reg1", out_reg1, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_state", stage_state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      in_valid = 1;
      in_pc = 32'h1000 + 32'(4 * i);
      in_ctrl = 16'(i + 1);
      in_we = 1;
      in_w_addr = 5'(i + 1);
      in_is_load = i[0];
      in_rs_read = vt[i].rs_read; in_rt_read = vt[i].rt_read;
      in_rs_addr = vt[i].rs_a; in_rt_addr = vt[i].rt_a;
      in_imm = vt[i].imm; rs_data = vt[i].rs_d;
      rt_data = vt[i].rt_d; fwd_we = vt[i].fwe;
      fwd_addr = vt[i].fa; fwd_data = vt[i].fd;
      fwd_pending = vt[i].fp;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].exp_rdy);
      chk($sformatf("v%0d_rs_addr", i), rs_addr, vt[i].rs_a);
      if (vt[i].exp_rdy) begin
        e.pc = in_pc; e.ctrl = in_ctrl; e.wa = in_w_addr;
        e.ld = in_is_load; e.r1 = vt[i].exp_r1;
        e.r2 = vt[i].exp_r2;
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].exp_rdy);
      chk($sformatf("v%0d_state", i), stage_state,
          vt[i].exp_rdy ? 2'd0 : 2'd1);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL v%0d_sb: got output expected none", i);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_reg1", i), out_reg1, e.r1);
          chk($sformatf("v%0d_reg2", i), out_reg2, e.r2);
          chk($sformatf("v%0d_pc", i), out_pc, e.pc);
          chk($sformatf("v%0d_ctrl", i), out_ctrl, e.ctrl);
          chk($sformatf("v%0d_waddr", i), out_w_addr, e.wa);
          chk($sformatf("v%0d_load", i), out_is_load, e.ld);
        end
      end
    end
    chk("sb_empty", sbq.size(), 0);

    // Load-use stall, then the value arrives on an older channel.
    @(negedge clk);
    idle();
    in_valid = 1; in_pc = 32'h4000; in_rs_read = 1;
    in_rs_addr = 8; fwd_we = 3'b001; fwd_addr = {10'd0, 5'd8};
    fwd_pending = 3'b001;
    #1 chk("lu_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("lu_out_valid", out_valid, 0);
    chk("lu_state", stage_state, 1);
    @(negedge clk);
    fwd_we = 3'b010; fwd_addr = {5'd0, 5'd8, 5'd0};
    fwd_data = {32'h0, 32'h1234, 32'h0}; fwd_pending = '0;
    #1 chk("lu2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("lu2_out_valid", out_valid, 1);
    chk("lu2_reg1", out_reg1, 32'h1234);
    chk("lu2_pc", out_pc, 32'h4000);
    chk("lu2_state", stage_state, 0);

    // Backpressure: slot must hold while new input waits.
    @(negedge clk);
    idle();
    in_valid = 1; in_pc = 32'h2000; in_rs_read = 1; in_rs_addr = 5;
    fwd_we = 3'b001; fwd_addr = {10'd0, 5'd5};
    fwd_data = {64'h0, 32'hABC};
    @(posedge clk);
    @(negedge clk);
    out_ready = 0; in_pc = 32'h3000;
    fwd_data = {64'h0, 32'hDEF};
    #1 chk("bp_in_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_pc", c), out_pc, 32'h2000);
      chk($sformatf("bp%0d_reg1", c), out_reg1, 32'hABC);
      chk($sformatf("bp%0d_state", c), stage_state, 2);
    end

    // Flush kills the slot and blocks acceptance.
    @(negedge clk);
    out_ready = 1; flush = 1;
    #1 chk("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_state", stage_state, 0);
    chk("fl_pc_hold", out_pc, 32'h2000);
    @(negedge clk);
    flush = 0;
    #1 chk("fl2_in_ready", in_ready, 1);

    // Stall counter over four load-use cycles.
    do_reset();
    chk("rst2_pc", out_pc, 0);
    chk("rst2_cnt", stall_cnt, 0);
    in_valid = 1; in_rs_read = 1; in_rs_addr = 8;
    fwd_we = 3'b001; fwd_addr = {10'd0, 5'd8}; fwd_pending = 3'b001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); #1;
`ifdef ID_STALL_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    chk("cnt_after_lu", stall_cnt, exp_cnt);
    chk("cnt_state_run", stage_state, 0);
    do_reset();
    chk("cnt_after_rst", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
